// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Owns the MIPS program counter. Issues one instruction-memory fetch at a
// time over a req/ack handshake, holds the fetched word for decode behind a
// valid/ready handshake, and advances the PC either sequentially
// (PC + PC_STEP, 32-bit wrap) or to a branch/jump redirect target.
//
// Optional feature: define FETCH_TIMEOUT_EN to add a fetch watchdog. When it
// is defined, TIMEOUT_CYCLES consecutive request cycles without an ack
// park the sequencer in an error state that only reset leaves. Without the
// macro a request waits indefinitely and fetch_error is tied low.
//
// Parameters
//   RESET_PC        PC loaded on reset
//   PC_STEP         sequential increment
//   TIMEOUT_CYCLES  watchdog limit (FETCH_TIMEOUT_EN builds only)
//
// Ports
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   enable          permits new fetches (never aborts an outstanding one)
//   redirect_valid  branch/jump taken this cycle
//   redirect_pc     redirect target, bits [1:0] forced to zero
//   imem_req        fetch request
//   imem_addr       fetch address (always the current PC)
//   imem_ack        memory accepted the request, imem_data valid
//   imem_data       fetched word
//   instr_valid     fetched instruction available to decode
//   instr_out       fetched instruction
//   instr_pc        address of instr_out
//   instr_ready     decode accepts the instruction
//   pc_out          current PC register
//   fetch_error     watchdog tripped
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] PC_STEP        = 32'd4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic        fetch_error
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  // Wide enough to hold TIMEOUT_CYCLES itself so the compare never aliases.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;
`endif

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr_out_q, instr_out_next;
  logic [31:0] instr_pc_q, instr_pc_next;
  logic        pend_valid, pend_valid_next;
  logic [31:0] pend_pc, pend_pc_next;

  logic [31:0] redirect_target;
  logic [31:0] pc_inc;
  state_t      resume_state;

  // Masking (rather than slicing) keeps every bit of redirect_pc in use.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc          = pc + PC_STEP;
  // Where the sequencer goes once it is free to start another fetch.
  assign resume_state    = enable ? S_REQ : S_IDLE;

`ifdef FETCH_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
`endif

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr_out_q <= 32'h0;
      instr_pc_q  <= 32'h0;
      pend_valid  <= 1'b0;
      pend_pc     <= 32'h0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr_out_q <= instr_out_next;
      instr_pc_q  <= instr_pc_next;
      pend_valid  <= pend_valid_next;
      pend_pc     <= pend_pc_next;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_next;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Next-state / next-datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    instr_out_next  = instr_out_q;
    instr_pc_next   = instr_pc_q;
    pend_valid_next = pend_valid;
    pend_pc_next    = pend_pc;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_next   = '0;
`endif

    case (state)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
        end
        state_next = resume_state;
      end

      S_REQ: begin
        if (imem_ack) begin
          pend_valid_next = 1'b0;
          if (redirect_valid || pend_valid) begin
            // The fetched word belongs to the wrong path: drop it and
            // refetch from the newest redirect target.
            pc_next    = redirect_valid ? redirect_target : pend_pc;
            state_next = resume_state;
          end else begin
            instr_out_next = imem_data;
            instr_pc_next  = pc;
            pc_next        = pc_inc;
            state_next     = S_HOLD;
          end
        end else begin
          // The request stays on the bus; remember where to go once it
          // completes. A later redirect overwrites an earlier one.
          if (redirect_valid) begin
            pend_valid_next = 1'b1;
            pend_pc_next    = redirect_target;
          end
`ifdef FETCH_TIMEOUT_EN
          if (wait_cnt == CNT_LAST) begin
            state_next = S_ERROR;
          end else begin
            wait_cnt_next = wait_cnt + 1'b1;
          end
`endif
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          // Squash (or, with instr_ready, complete) the held instruction
          // and continue from the target.
          pc_next    = redirect_target;
          state_next = resume_state;
        end else if (instr_ready) begin
          state_next = resume_state;
        end
      end

`ifdef FETCH_TIMEOUT_EN
      S_ERROR: begin
        state_next = S_ERROR;
      end
`endif

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign pc_out      = pc;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_error = (state == S_ERROR);
`else
  assign fetch_error = 1'b0;
`endif

endmodule
